pulse_peak_detect: RTL

- Downstream consumer of the decaying-pulse generator's 14-bit signed sample stream, one sample per clk.
- Detects each pulse crossing a programmable threshold and tracks its maximum, width above threshold and a pile-up indication.
- Emits one event record per accepted pulse over a valid/ready interface to the histogram/readout stage.

---
 rtl/pulse_peak_detect.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pulse_peak_detect.sv
// Threshold-crossing pulse detector: tracks peak, width and pile-up, and emits one record per accepted pulse.
// Optional PULSE_PEAK_TIMESTAMP_EN adds a free-running 32-bit timestamp captured at the peak (out_ts).
module pulse_peak_detect #(
  parameter int W          = 14,
  parameter int CNT_W      = 16,
  parameter int MIN_WIDTH  = 2,
  parameter int PILE_DELTA = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] thr,
  input  logic                out_ready,
  output logic                out_valid,
  output logic signed [W-1:0] out_peak,
  output logic [CNT_W-1:0]    out_width,
  output logic                out_pileup,
  output logic [CNT_W-1:0]    drop_cnt,
`ifdef PULSE_PEAK_TIMESTAMP_EN
  output logic [31:0]         out_ts,
`endif
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;

  state_t              state;
  logic signed [W-1:0] peak;
  logic signed [W-1:0] prev;
  logic [CNT_W-1:0]    width;
  logic                pile;

  logic                above;
  logic signed [W:0]   x_ext;
  logic signed [W:0]   prev_lim;
  logic [CNT_W-1:0]    width_inc;
  logic [CNT_W-1:0]    drop_inc;
  logic                slot_free;
  logic                accept;
  logic                keep;

  assign above     = x > thr;
  // One extra bit so prev+PILE_DELTA cannot wrap near the positive limit.
  assign x_ext     = {x[W-1], x};
  assign prev_lim  = $signed({prev[W-1], prev}) + $signed((W+1)'(PILE_DELTA));
  assign width_inc = (&width) ? width : width + 1'b1;
  assign drop_inc  = (&drop_cnt) ? drop_cnt : drop_cnt + 1'b1;
  assign slot_free = !out_valid || out_ready;
  assign accept    = out_valid && out_ready;
  assign keep      = width >= CNT_W'(MIN_WIDTH);
  assign busy      = (state != IDLE);

`ifdef PULSE_PEAK_TIMESTAMP_EN
  logic [31:0] ts;
  logic [31:0] peak_ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts <= '0;
    end else begin
      ts <= ts + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      peak       <= '0;
      prev       <= '0;
      width      <= '0;
      pile       <= 1'b0;
      out_valid  <= 1'b0;
      out_peak   <= '0;
      out_width  <= '0;
      out_pileup <= 1'b0;
      drop_cnt   <= '0;
`ifdef PULSE_PEAK_TIMESTAMP_EN
      peak_ts    <= '0;
      out_ts     <= '0;
`endif
    end else begin
      // A load in the same cycle overrides this clear (back-to-back records).
      if (accept) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (above) begin
            state <= RISE;
            peak  <= x;
            prev  <= x;
            width <= CNT_W'(1);
            pile  <= 1'b0;
`ifdef PULSE_PEAK_TIMESTAMP_EN
            peak_ts <= ts;
`endif
          end
        end

        RISE, FALL: begin
          if (above) begin
            width <= width_inc;
            prev  <= x;
            if (x > peak) begin
              peak <= x;
`ifdef PULSE_PEAK_TIMESTAMP_EN
              peak_ts <= ts;
`endif
            end
            if (state == RISE && x < prev) begin
              state <= FALL;
            end
            if (state == FALL && x_ext > prev_lim) begin
              pile <= 1'b1;
            end
          end else begin
            state <= IDLE;
            if (keep) begin
              if (slot_free) begin
                out_valid  <= 1'b1;
                out_peak   <= peak;
                out_width  <= width;
                out_pileup <= pile;
`ifdef PULSE_PEAK_TIMESTAMP_EN
                out_ts     <= peak_ts;
`endif
              end else begin
                drop_cnt <= drop_inc;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
